// File: rtl/single_clk_ram_128x16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : single_clk_ram_128x16_pkg
//  Description : Shared sizing defaults and clear-sequencer state encoding
//                for the 128x16 single-clock RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package single_clk_ram_128x16_pkg;

   localparam int RAM_DATA_WIDTH = 16;
   localparam int RAM_ADDR_WIDTH = 7;
   localparam int RAM_DEPTH      = 2 ** RAM_ADDR_WIDTH;

   // Clear sequencer states: IDLE when the array is usable, CLEAR while
   // the post-reset zeroing sweep is running.
   typedef enum logic [0:0] {
      CLR_IDLE  = 1'b0,
      CLR_CLEAR = 1'b1
   } clr_state_t;

endpackage : single_clk_ram_128x16_pkg
`default_nettype wire

// File: rtl/single_clk_ram_128x16_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ram_clear_seq
//  Description : Walks a pointer over every word after reset so the RAM
//                can zero one location per clock; flags the sweep as active.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_clear_seq
   import single_clk_ram_128x16_pkg::*;
#(
   parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  clearing,
   output logic [ADDR_WIDTH-1:0] ptr
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] C_LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   clr_state_t            r_state;
   clr_state_t            w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [ADDR_WIDTH-1:0] w_ptr_nxt;

   // State and pointer registers; reset restarts the sweep from word 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= CLR_CLEAR;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // Advance one word per clock while clearing; leave CLEAR after the last word.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         CLR_CLEAR: begin
            w_ptr_nxt = r_ptr + C_PTR_ONE;
            if (r_ptr == C_LAST_PTR) begin
               w_state_nxt = CLR_IDLE;
            end
         end
         default: begin
            w_state_nxt = CLR_IDLE;
         end
      endcase
   end

   assign clearing = (r_state == CLR_CLEAR);
   assign ptr      = r_ptr;

endmodule : ram_clear_seq
`default_nettype wire

// File: rtl/single_clk_ram_128x16.sv
`default_nettype none
// ============================================================================
//  Module      : single_clk_ram_128x16
//  Description : Single-port single-clock RAM with registered read address,
//                write-through reads and a reset-triggered clear sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module single_clk_ram_128x16
   import single_clk_ram_128x16_pkg::*;
#(
   parameter int DATA_WIDTH = RAM_DATA_WIDTH,
   parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  we,
   input  logic                  clk,
   output logic [DATA_WIDTH-1:0] q,
   input  logic                  rst
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_addr_q;

   logic                  w_clearing;
   logic [ADDR_WIDTH-1:0] w_ptr;

   logic                  w_wr_en;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic [DATA_WIDTH-1:0] w_wr_data;

   ram_clear_seq #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_seq (
      .clk      (clk),
      .rst      (rst),
      .clearing (w_clearing),
      .ptr      (w_ptr)
   );

   // Single write port: the sweep owns it while clearing, the user otherwise;
   // nothing is written on a reset edge.
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_addr = addr;
      w_wr_data = data;
      if (!rst) begin
         if (w_clearing) begin
            w_wr_en   = 1'b1;
            w_wr_addr = w_ptr;
            w_wr_data = '0;
         end else begin
            w_wr_en   = we;
         end
      end
   end

   // Memory array write; no reset so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_addr] <= w_wr_data;
      end
   end

   // Registered read address; keeps tracking addr during the sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr_q <= '0;
      end else begin
         r_addr_q <= addr;
      end
   end

   // Read data is hidden while reset or the sweep is active.
   assign q = (w_clearing || rst) ? '0 : r_mem[r_addr_q];

endmodule : single_clk_ram_128x16
`default_nettype wire

// File: tb/tb_single_clk_ram_128x16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_single_clk_ram_128x16
//  Description : Self-checking bench for single_clk_ram_128x16 with an
//                array-based reference model and directed plus random steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_single_clk_ram_128x16;

   logic        clk;
   logic        rst;
   logic        we;
   logic [6:0]  addr;
   logic [15:0] data;
   logic [15:0] q;

   int vectors;
   int miscompares;

   // Reference model: plain storage plus count of sweep words still to clear.
   logic [15:0] model [128];
   int          sweep_left;
   logic [6:0]  m_addr_q;
   logic [15:0] m_exp;

   single_clk_ram_128x16 dut (
      .data (data),
      .addr (addr),
      .we   (we),
      .clk  (clk),
      .q    (q),
      .rst  (rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] exp_val);
      vectors++;
      assert (q === exp_val) else begin
         miscompares++;
         $error("FAIL %s: q observed %h expected %h", tag, q, exp_val);
      end
   endtask

   // One clock: drive inputs at negedge, advance the model at posedge, check after.
   task automatic step(input logic r, input logic w, input logic [6:0] a,
                       input logic [15:0] d, input string tag);
      @(negedge clk);
      rst = r; we = w; addr = a; data = d;
      @(posedge clk);
      #1;
      if (r) begin
         sweep_left = 128;
      end else if (sweep_left > 0) begin
         model[128 - sweep_left] = 16'h0000;
         sweep_left--;
      end else if (w) begin
         model[a] = d;
      end
      m_addr_q = r ? 7'd0 : a;
      m_exp = (r || sweep_left > 0) ? 16'h0000 : model[m_addr_q];
      check(tag, m_exp);
   endtask

   initial begin
      logic [15:0] rd;
      vectors = 0;
      miscompares = 0;
      sweep_left = 128;
      m_addr_q = '0;
      for (int i = 0; i < 128; i++) model[i] = 16'h0000;
      rst = 1'b1; we = 1'b0; addr = '0; data = '0;

      // Reset sweep with write enable held high: all writes ignored.
      step(1'b1, 1'b0, 7'd0, 16'h0000, "reset");
      step(1'b1, 1'b1, 7'd5, 16'hFFFF, "reset");
      for (int i = 0; i < 128; i++)
         step(1'b0, 1'b1, 7'($urandom_range(0, 127)), 16'hFFFF, "sweep");
      for (int i = 0; i < 128; i++)
         step(1'b0, 1'b0, 7'(i), 16'h0000, "post_sweep_read");

      // Basic write/read and neighbour.
      step(1'b0, 1'b1, 7'd7, 16'hA5C3, "write7");
      step(1'b0, 1'b0, 7'd7, 16'h0000, "read7");
      check("read7_const", 16'hA5C3);
      step(1'b0, 1'b0, 7'd8, 16'h0000, "read8");
      check("read8_const", 16'h0000);

      // Read-during-write.
      step(1'b0, 1'b1, 7'd3, 16'h1234, "rdw3");
      check("rdw3_const", 16'h1234);

      // Read-modify-write nibble packing at addr 0.
      step(1'b0, 1'b0, 7'd0, 16'h0000, "rmw_read");
      for (int n = 0; n < 4; n++) begin
         rd = q;
         rd[n*4 +: 4] = 4'b1001;
         step(1'b0, 1'b1, 7'd0, rd, "rmw_write");
      end
      check("rmw_final", 16'h9999);

      // Address extremes.
      step(1'b0, 1'b1, 7'd0,   16'h0001, "wr_lo");
      step(1'b0, 1'b1, 7'd127, 16'h8000, "wr_hi");
      step(1'b0, 1'b0, 7'd0,   16'h0000, "rd_lo");
      check("rd_lo_const", 16'h0001);
      step(1'b0, 1'b0, 7'd127, 16'h0000, "rd_hi");
      check("rd_hi_const", 16'h8000);

      // Back-to-back writes to one address: last wins.
      step(1'b0, 1'b1, 7'd50, 16'h1111, "b2b_1");
      step(1'b0, 1'b1, 7'd50, 16'h2222, "b2b_2");
      step(1'b0, 1'b0, 7'd50, 16'h0000, "b2b_rd");
      check("b2b_const", 16'h2222);

      // Random traffic.
      for (int i = 0; i < 300; i++)
         step(1'b0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
              16'($urandom), "random");

      // Reset mid-sweep restarts the clear.
      step(1'b0, 1'b1, 7'd100, 16'hBEEF, "wr_beef");
      step(1'b1, 1'b0, 7'd100, 16'h0000, "rst_a");
      for (int i = 0; i < 59; i++)
         step(1'b0, 1'b1, 7'($urandom_range(0, 127)), 16'($urandom), "sweep_a");
      step(1'b1, 1'b1, 7'd100, 16'hBEEF, "rst_b");
      for (int i = 0; i < 128; i++)
         step(1'b0, 1'b1, 7'($urandom_range(0, 127)), 16'($urandom), "sweep_b");
      step(1'b0, 1'b0, 7'd100, 16'h0000, "rd_beef");
      check("rd_beef_const", 16'h0000);
      for (int i = 0; i < 128; i++)
         step(1'b0, 1'b0, 7'(i), 16'h0000, "post_sweep_b_read");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_single_clk_ram_128x16
`default_nettype wire
